// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way select stage.
package mux_pkg;

  // Largest supported number of input words.
  localparam int MUX_MAX_IN = 16;

  // Occupancy of the two-entry skid buffer. The encoding is the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Width of the select index. It is never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Handshake bundle between a producer and the registered select stage.
interface pipe_mux_n_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4
);

  localparam int SEL_W = sel_w(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            occupancy;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_err, out_valid, occupancy
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_err, out_valid, occupancy
  );

endinterface

// File: rtl/skid_buf.sv
// Two-entry skid buffer: main register M drives the output, skid register S
// absorbs the word accepted in the cycle back-pressure appears.
module skid_buf
  import mux_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] in_word,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    occupancy
);

  skid_state_t   state;
  skid_state_t   state_n;
  logic [DW-1:0] skid_word;
  logic          in_xfer;
  logic          out_xfer;
  logic          load_m_in;
  logic          load_m_skid;
  logic          load_skid;

  // Both handshakes use only registered flags, so in_ready never depends
  // combinationally on out_ready or in_valid.
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Next state and register load selects; flush overrides every transfer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n     = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_skid   = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_m_in = 1'b1;
            state_n   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_m_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_n   = FULL;
          end else if (out_xfer) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            load_m_skid = 1'b1;
            state_n     = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // State, data registers and registered flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so out_data reads 0 after reset.
      state     <= EMPTY;
      out_word  <= '0;
      skid_word <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_n;
      if (load_m_in) begin
        out_word <= in_word;
      end else if (load_m_skid) begin
        out_word <= skid_word;
      end
      if (load_skid) begin
        skid_word <= in_word;
      end
      in_ready  <= (state_n != FULL);
      out_valid <= (state_n != EMPTY);
      occupancy <= state_n;
    end
  end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N-way word select with valid/ready handshake and flush.
// Out-of-range selects forward zero with the error flag set.
module pipe_mux_n
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_mux_n_if.slave  bus
);

  localparam int SEL_W = sel_w(N_IN);
  // Never scan beyond the supported input count.
  localparam int N_SEL = (N_IN < MUX_MAX_IN) ? N_IN : MUX_MAX_IN;

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;
  logic [WIDTH:0]   out_word;

  // Select the indexed word; an index with no matching word flags an error.
  always_comb begin
    sel_word = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < N_SEL; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_word = bus.in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  skid_buf #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_word   ({sel_err, sel_word}),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .out_word  (out_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .occupancy (bus.occupancy)
  );

  assign bus.out_data = out_word[WIDTH-1:0];
  assign bus.out_err  = out_word[WIDTH];

endmodule
